// File: rtl/uart_rx.sv
// uart_rx: UART 8N1 receiver. Samples rx at mid-bit, rebuilds bytes LSB first,
// and hands each byte over through a one-entry valid/ready holding register.
// Ports:
//   clk       - system clock, all logic on posedge
//   rst       - synchronous active-high reset
//   rx        - asynchronous serial input, idle high
//   rx_data   - received byte, stable while rx_valid=1
//   rx_valid  - holding register full
//   rx_ready  - consumer accepts; transfer on rx_valid && rx_ready
//   frame_err - 1-cycle pulse: stop bit low, byte discarded
//   overrun   - 1-cycle pulse: byte completed while holding register full, byte dropped
//   busy      - receiver not in IDLE
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    shift, shift_d;
  logic          done, done_d;
  logic          ferr_d;
  logic          rx_meta, rx_s;

  // Two-stage synchroniser; reset to the idle-line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      shift     <= shift_d;
      done      <= done_d;
      frame_err <= ferr_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shift_d = shift;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_d          = '0;
          shift_d[idx]   = rx_s;
          idx_d          = idx + 1'b1;
          if (idx == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Delivery happens the cycle after the stop-bit sample; a same-cycle
  // consume frees the slot so the new byte loads instead of overrunning.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
